// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one strobe/ready memory port between the I-cache and D-cache.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests.
module mem_bus_arbiter #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  // instruction side
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        i_rdata,
  input  logic               i_strobe,
  input  logic [3:0]         i_wen,
  input  logic [1:0]         i_size,
  input  logic               i_rw,
  output logic               i_ready,
  // data side
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_wdata,
  output logic [31:0]        d_rdata,
  input  logic               d_strobe,
  input  logic [3:0]         d_wen,
  input  logic [1:0]         d_size,
  input  logic               d_rw,
  output logic               d_ready,
  // memory port
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_wdata,
  input  logic [31:0]        m_rdata,
  output logic               m_strobe,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  output logic               m_rw,
  input  logic               m_ready,
  // ownership
  output logic               gnt_i,
  output logic               gnt_d
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_e;
  typedef enum logic {OWNER_I, OWNER_D} owner_e;

  state_e state_q, state_d;
  owner_e last_owner_q, last_owner_d;
  logic   pick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_I;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the side that did not complete last goes first.
  always_comb pick_d = d_strobe && (!i_strobe || (last_owner_q == OWNER_I));
`else
  always_comb pick_d = d_strobe;
`endif

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (pick_d)        state_d = OWN_D;
        else if (i_strobe) state_d = OWN_I;
      end
      OWN_I: begin
        // Completion takes precedence over a same-cycle withdrawal.
        if (m_ready) begin
          state_d      = IDLE;
          last_owner_d = OWNER_I;
        end else if (!i_strobe) begin
          state_d = IDLE;
        end
      end
      OWN_D: begin
        if (m_ready) begin
          state_d      = IDLE;
          last_owner_d = OWNER_D;
        end else if (!d_strobe) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port is a pure mux of the owner's request; quiet in IDLE.
  always_comb begin
    m_a      = '0;
    m_wdata  = '0;
    m_strobe = 1'b0;
    m_wen    = '0;
    m_size   = '0;
    m_rw     = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    case (state_q)
      OWN_I: begin
        m_a      = i_a;
        m_wdata  = i_wdata;
        m_strobe = i_strobe;
        m_wen    = i_wen;
        m_size   = i_size;
        m_rw     = i_rw;
        i_ready  = m_ready && !rst;
      end
      OWN_D: begin
        m_a      = d_a;
        m_wdata  = d_wdata;
        m_strobe = d_strobe;
        m_wen    = d_wen;
        m_size   = d_size;
        m_rw     = d_rw;
        d_ready  = m_ready && !rst;
      end
      default: ;
    endcase
  end

  // Both sides see the shared read bus; each qualifies it with its own ready.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  assign gnt_i = (state_q == OWN_I);
  assign gnt_d = (state_q == OWN_D);

endmodule
